// File: rtl/golay_probe_tx.sv
// golay_probe_tx
//   Channel-sounding probe source. Emits SC16 AXI-stream frames built from a
//   Golay complementary pair (Ga, Gb) of length N = 2**SEQ_LOG2:
//     frame = num_reps x (Ga, Gb) followed by guard_len zero samples.
//   o_tlast marks the final beat of each frame. num_reps, guard_len and amp are
//   captured when a frame is accepted and reused for continuous restarts.
//
// Ports
//   ce_clk      clock
//   ce_rst      synchronous active-high reset
//   clear       synchronous abort; same effect as ce_rst, wins over start
//   start       frame request, only looked at while idle
//   continuous  restart a new frame straight after the tlast handshake
//   num_reps    Ga/Gb pair count per frame (0 = start ignored)
//   guard_len   trailing zero samples per frame
//   amp         signed probe amplitude; sample I = +amp or -amp, Q = 0
//   o_tdata     {I, Q} SC16 sample
//   o_tvalid    stream valid (registered)
//   o_tlast     last beat of frame (registered)
//   o_tready    stream ready
//   busy        a frame is in progress
//   frame_cnt   completed frames (tlast handshakes), wrapping
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | no frame; outputs zero, waiting for start
// SEQ_A | presenting Ga sample k of pair rep
// SEQ_B | presenting Gb sample k of pair rep
// GUARD | presenting guard zero g
//
// The registered state/counters always describe the beat currently sitting on
// the output. On a handshake the next position is computed combinationally and
// both the position and the matching beat are loaded together, so a stalled
// beat is simply held and o_tready never reaches o_tvalid combinationally.

module golay_probe_tx #(
  parameter int SEQ_LOG2 = 7,
  parameter int CNT_W    = 16
) (
  input  logic             ce_clk,
  input  logic             ce_rst,
  input  logic             clear,
  input  logic             start,
  input  logic             continuous,
  input  logic [7:0]       num_reps,
  input  logic [15:0]      guard_len,
  input  logic [15:0]      amp,
  output logic [31:0]      o_tdata,
  output logic             o_tvalid,
  output logic             o_tlast,
  input  logic             o_tready,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SEQ_A = 2'd1,
    SEQ_B = 2'd2,
    GUARD = 2'd3
  } state_t;

  localparam logic [SEQ_LOG2-1:0] K_MAX = '1;

  state_t                state;
  logic [SEQ_LOG2-1:0]   k;
  logic [7:0]            rep;
  logic [15:0]           g;
  logic [7:0]            reps_q;
  logic [15:0]           guard_q;
  logic [15:0]           amp_q;

  state_t                nxt_state;
  logic [SEQ_LOG2-1:0]   nxt_k;
  logic [7:0]            nxt_rep;
  logic [15:0]           nxt_g;
  logic [7:0]            nxt_reps;
  logic [15:0]           nxt_guard;
  logic [15:0]           nxt_amp;
  logic [31:0]           nxt_data;
  logic                  nxt_last;
  logic                  load;
  logic                  frame_end;
  logic                  beat_done;
  logic [7:0]            rep_inc;

  // Negation saturates: -(-32768) is not representable, clamp to +32767.
  function automatic logic [15:0] neg_sat(input logic [15:0] a);
    if (a == 16'h8000) return 16'h7FFF;
    return ~a + 16'd1;
  endfunction

  // Golay pair sign: Ga from the parity of adjacent-bit ANDs of the index,
  // Gb additionally flipped in the upper half.
  function automatic logic seq_sign(input state_t st, input logic [SEQ_LOG2-1:0] kk);
    logic sa;
    sa = ^(kk & (kk >> 1));
    return (st == SEQ_B) ? (sa ^ kk[SEQ_LOG2-1]) : sa;
  endfunction

  assign beat_done = o_tvalid && o_tready;
  assign rep_inc   = rep + 8'd1;

  always_comb begin
    nxt_state = state;
    nxt_k     = k;
    nxt_rep   = rep;
    nxt_g     = g;
    nxt_reps  = reps_q;
    nxt_guard = guard_q;
    nxt_amp   = amp_q;
    load      = 1'b0;
    frame_end = 1'b0;

    case (state)
      IDLE: begin
        if (start && (num_reps != 8'd0)) begin
          nxt_state = SEQ_A;
          nxt_k     = '0;
          nxt_rep   = '0;
          nxt_g     = '0;
          nxt_reps  = num_reps;
          nxt_guard = guard_len;
          nxt_amp   = amp;
          load      = 1'b1;
        end
      end
      SEQ_A: begin
        if (beat_done) begin
          load = 1'b1;
          if (k == K_MAX) begin
            nxt_state = SEQ_B;
            nxt_k     = '0;
          end else begin
            nxt_k = k + 1'b1;
          end
        end
      end
      SEQ_B: begin
        if (beat_done) begin
          load = 1'b1;
          if (k != K_MAX) begin
            nxt_k = k + 1'b1;
          end else if (rep_inc < reps_q) begin
            nxt_state = SEQ_A;
            nxt_k     = '0;
            nxt_rep   = rep_inc;
          end else if (guard_q != 16'd0) begin
            nxt_state = GUARD;
            nxt_g     = '0;
            nxt_rep   = rep_inc;
          end else begin
            frame_end = 1'b1;
          end
        end
      end
      GUARD: begin
        if (beat_done) begin
          load = 1'b1;
          if (g == guard_q - 16'd1) begin
            frame_end = 1'b1;
          end else begin
            nxt_g = g + 16'd1;
          end
        end
      end
      default: begin
        nxt_state = IDLE;
      end
    endcase

    // Frame end either rolls straight into a new frame with the captured
    // settings (no bubble) or drops back to idle with valid low.
    if (frame_end) begin
      if (continuous) begin
        nxt_state = SEQ_A;
        nxt_k     = '0;
        nxt_rep   = '0;
        nxt_g     = '0;
      end else begin
        nxt_state = IDLE;
        load      = 1'b0;
      end
    end

    nxt_data = 32'd0;
    if ((nxt_state == SEQ_A) || (nxt_state == SEQ_B)) begin
      nxt_data = {(seq_sign(nxt_state, nxt_k) ? neg_sat(nxt_amp) : nxt_amp), 16'h0000};
    end

    nxt_last = ((nxt_state == SEQ_B) && (nxt_k == K_MAX) &&
                (nxt_rep == nxt_reps - 8'd1) && (nxt_guard == 16'd0)) ||
               ((nxt_state == GUARD) && (nxt_g == nxt_guard - 16'd1));
  end

  always_ff @(posedge ce_clk) begin
    if (ce_rst || clear) begin
      state     <= IDLE;
      k         <= '0;
      rep       <= '0;
      g         <= '0;
      reps_q    <= '0;
      guard_q   <= '0;
      amp_q     <= '0;
      o_tdata   <= '0;
      o_tvalid  <= 1'b0;
      o_tlast   <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state   <= nxt_state;
      k       <= nxt_k;
      rep     <= nxt_rep;
      g       <= nxt_g;
      reps_q  <= nxt_reps;
      guard_q <= nxt_guard;
      amp_q   <= nxt_amp;
      busy    <= (nxt_state != IDLE);
      if (frame_end) begin
        frame_cnt <= frame_cnt + 1'b1;
      end
      if (load) begin
        o_tvalid <= 1'b1;
        o_tdata  <= nxt_data;
        o_tlast  <= nxt_last;
      end else if (nxt_state == IDLE) begin
        o_tvalid <= 1'b0;
        o_tdata  <= '0;
        o_tlast  <= 1'b0;
      end
    end
  end

endmodule
